boot_load_ctrl: RTL and testbench
=================================

// Module: boot_load_ctrl
// PURPOSE
// Sequences a UART boot load into program memory. It sits between the boot hex
// parser (word stream), the CPU memory port and the single-port program memory.
// While a load is active it holds the CPU in reset and owns the memory port.
// It buffers parser words and writes them to memory, then releases the CPU.
// PARAMETERS
// ADDR_W          32  word address width (parser address = memory word address)
// DATA_W          32  memory word width
// FIFO_DEPTH      4   boot word buffer entries (power of 2, >=2)
// RELEASE_CYCLES  16  cycles cpu_reset is held after the last boot write
// CNT_W           16  width of words_loaded counter
// PORTS
// clk            in   1         clock
// reset          in   1         asynchronous, active-high
// boot_valid     in   1         parser word strobe
// boot_addr      in   ADDR_W    parser word address
// boot_data      in   DATA_W    parser word data
// boot_busy      in   1         parser activity (high = load in progress)
// boot_error     in   1         parser character error
// cpu_req        in   1         CPU memory request
// cpu_we         in   1         CPU write enable
// cpu_addr       in   ADDR_W    CPU word address
// cpu_wdata      in   DATA_W    CPU write data
// cpu_be         in   DATA_W/8  CPU byte enables
// cpu_ready      out  1         CPU request accepted this cycle
// mem_req        out  1         memory request
// mem_we         out  1         memory write enable
// mem_addr       out  ADDR_W    memory word address
// mem_wdata      out  DATA_W    memory write data
// mem_be         out  DATA_W/8  memory byte enables
// mem_ready      in   1         memory accepts request this cycle
// cpu_reset      out  1         CPU reset (active-high)
// load_error     out  1         sticky: parser error or buffer overflow in current load
// words_loaded   out  CNT_W     words written in current load; saturates at all-ones
// boot_done      out  1         one-cycle pulse when the CPU is released
// BEHAVIOUR
// - Reset: state=RELEASE, release counter=RELEASE_CYCLES-1, FIFO empty.
//   cpu_reset=1, load_error=0, words_loaded=0, boot_done=0. mem_req=0 while the FIFO is empty.
// - States: IDLE, LOAD, DRAIN, RELEASE. Registered state; the memory mux is combinational.
// - IDLE: cpu_reset=0. mem_* = cpu_* with mem_req=cpu_req, and cpu_ready=mem_ready.
//   On boot_busy=1, go to LOAD next cycle. Entering LOAD from IDLE clears load_error and
//   words_loaded, and asserts cpu_reset next cycle. A CPU request not yet accepted is abandoned.
// - LOAD/DRAIN/RELEASE: cpu_reset=1, cpu_ready=0, CPU inputs ignored.
//   mem_req=!fifo_empty, mem_we=1, mem_be=all ones, mem_addr/mem_wdata=FIFO head.
// - FIFO push: boot_valid in any non-IDLE state. Pop: mem_req&&mem_ready.
//   Push+pop on the same cycle when full is legal and is not an overflow.
//   Push when full without pop: drop the word, set load_error.
// - boot_valid in IDLE (only possible before busy is seen) is pushed and
//   the controller moves to LOAD on the same edge.
// - boot_error=1 in LOAD/DRAIN sets load_error (sticky until the next IDLE->LOAD).
// - Each pop increments words_loaded (saturating).
// - LOAD -> DRAIN when boot_busy=0. DRAIN -> RELEASE when the FIFO is empty and no push
//   is pending; this reloads the counter to RELEASE_CYCLES-1.
// - RELEASE: decrement the counter; at 0 go to IDLE and pulse boot_done for that one cycle.
// - boot_busy=1 in DRAIN or RELEASE returns to LOAD. Buffered words are kept, and
//   load_error and words_loaded are NOT cleared (same load).
// - The FIFO is empty on any RELEASE->IDLE exit by construction.
// - Reset mid-load: FIFO flushed, partial memory contents left as written.
// STRUCTURE
// - Package boot_pkg: boot_state_t enum {IDLE, LOAD, DRAIN, RELEASE}, plus default width
//   localparams. The parser shares these.
// - Sub-module boot_word_fifo: synchronous FIFO of {addr,data}, with push/pop/full/empty
//   and same-cycle push+pop when full.
// - Top level: FSM, release counter, memory/CPU mux, error/counter registers.
// TESTING
// 1 Reset, no boot activity: cpu_reset=1 for exactly 16 cycles, boot_done pulses once,
//   then cpu_req/addr 0x10 reaches mem_* with cpu_ready=mem_ready.
// 2 busy=1, then 4 words at addr 0..3 (data 0xA0..0xA3), mem_ready=1, busy=0:
//   4 writes in order, words_loaded=4, load_error=0, cpu_reset released 16 cycles after drain.
// 3 mem_ready=0 while 5 words arrive: 5th dropped, load_error=1.
//   Then mem_ready=1: words 0..3 written, words_loaded=4.
// 4 FIFO full with push and pop on the same cycle: no error, order preserved.
// 5 boot_error pulse mid-load: load_error=1 through release. A new load from IDLE
//   clears it to 0 and words_loaded to 0.
// 6 busy re-asserted in RELEASE: back to LOAD, cpu_reset stays 1, no boot_done.
//   words_loaded continues counting from its previous value.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared boot-load types and default widths, used by the hex parser and
// the boot load controller.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } boot_state_t;

  localparam int BOOT_ADDR_W         = 32;
  localparam int BOOT_DATA_W         = 32;
  localparam int BOOT_FIFO_DEPTH     = 4;
  localparam int BOOT_RELEASE_CYCLES = 16;
  localparam int BOOT_CNT_W          = 16;

endpackage

// File: rtl/boot_word_fifo.sv
// Synchronous {addr,data} FIFO for boot words. A push while full is accepted
// only when a pop happens on the same cycle.
module boot_word_fifo
  import boot_pkg::*;
#(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W,
  parameter int DEPTH  = BOOT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W+DATA_W-1:0] store [DEPTH];
  logic [PTR_W:0]           wr_ptr;
  logic [PTR_W:0]           rd_ptr;
  logic                     push_en;
  logic                     pop_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign {head_addr, head_data} = store[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) store[wr_ptr[PTR_W-1:0]] <= {push_addr, push_data};
  end

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot load controller: buffers parser words, writes them into program memory
// while holding the CPU in reset, then hands the memory port back to the CPU.
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W         = BOOT_ADDR_W,
  parameter int DATA_W         = BOOT_DATA_W,
  parameter int FIFO_DEPTH     = BOOT_FIFO_DEPTH,
  parameter int RELEASE_CYCLES = BOOT_RELEASE_CYCLES,
  parameter int CNT_W          = BOOT_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                boot_valid,
  input  logic [ADDR_W-1:0]   boot_addr,
  input  logic [DATA_W-1:0]   boot_data,
  input  logic                boot_busy,
  input  logic                boot_error,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  output logic                cpu_reset,
  output logic                load_error,
  output logic [CNT_W-1:0]    words_loaded,
  output logic                boot_done
);

  localparam int          REL_W    = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_CYCLES - 1);

  boot_state_t       state;
  logic [REL_W-1:0]  rel_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              overflow;

  // Handshakes: a memory transfer happens on any cycle with mem_req && mem_ready;
  // in boot mode mem_req/addr/data hold the FIFO head until accepted. boot_valid
  // has no back-pressure: a word arriving while the FIFO is full and not popping
  // is dropped and flagged in load_error.
  assign pop      = (state != IDLE) && !fifo_empty && mem_ready;
  assign overflow = boot_valid && fifo_full && !pop;

  boot_word_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (boot_valid),
    .push_addr (boot_addr),
    .push_data (boot_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RELEASE;
      rel_cnt      <= REL_INIT;
      cpu_reset    <= 1'b1;
      load_error   <= 1'b0;
      words_loaded <= '0;
      boot_done    <= 1'b0;
    end else begin
      boot_done <= 1'b0;
      if (pop && (words_loaded != {CNT_W{1'b1}})) words_loaded <= words_loaded + 1'b1;
      if (overflow || (boot_error && (state == LOAD || state == DRAIN))) load_error <= 1'b1;

      case (state)
        IDLE: begin
          // A word seen before busy still starts the load; it is pushed on this edge.
          if (boot_busy || boot_valid) begin
            state        <= LOAD;
            cpu_reset    <= 1'b1;
            load_error   <= 1'b0;
            words_loaded <= '0;
          end
        end
        LOAD: begin
          if (!boot_busy) state <= DRAIN;
        end
        DRAIN: begin
          if (boot_busy) begin
            state <= LOAD;
          end else if (fifo_empty && !boot_valid) begin
            state   <= RELEASE;
            rel_cnt <= REL_INIT;
          end
        end
        RELEASE: begin
          if (boot_busy) begin
            state <= LOAD;
          end else if (!fifo_empty || boot_valid) begin
            state <= DRAIN;
          end else if (rel_cnt == '0) begin
            state     <= IDLE;
            cpu_reset <= 1'b0;
            boot_done <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = !fifo_empty;
    mem_we    = 1'b1;
    mem_addr  = head_addr;
    mem_wdata = head_data;
    mem_be    = '1;
    if (state == IDLE) begin
      cpu_ready = mem_ready;
      mem_req   = cpu_req;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end
  end

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Directed bench for boot_load_ctrl: table of CPU pass-through vectors plus
// hand-written load sequences checked against an expected-write queue.
module tb_boot_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_valid;
  logic [31:0] boot_addr;
  logic [31:0] boot_data;
  logic        boot_busy;
  logic        boot_error;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        cpu_reset;
  logic        load_error;
  logic [15:0] words_loaded;
  logic        boot_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        mem_ready;
    logic        exp_req;
    logic        exp_we;
    logic        exp_ready;
  } idle_vec_t;

  idle_vec_t vecs[4];

  boot_load_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .boot_valid   (boot_valid),
    .boot_addr    (boot_addr),
    .boot_data    (boot_data),
    .boot_busy    (boot_busy),
    .boot_error   (boot_error),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_be       (cpu_be),
    .cpu_ready    (cpu_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .cpu_reset    (cpu_reset),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .boot_done    (boot_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input bit kept);
    boot_valid = 1'b1;
    boot_addr  = a;
    boot_data  = d;
    if (kept) exp_q.push_back({a, d});
    tick();
    boot_valid = 1'b0;
  endtask

  task automatic start_load(input logic rdy);
    mem_ready = rdy;
    boot_busy = 1'b1;
    tick();
  endtask

  task automatic wait_release(output int n, output int dones);
    n = 0;
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      if (boot_done) dones++;
      if (!cpu_reset) break;
      n++;
      tick();
    end
  endtask

  // scoreboard: every boot-mode memory write must match the next expected word
  always @(negedge clk) begin
    if (!reset && cpu_reset && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h, expected none", {mem_addr, mem_wdata});
      end else begin
        chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
        chk("mem_we_be", {59'd0, mem_we, mem_be}, {59'd0, 1'b1, 4'hF});
      end
    end
  end

  initial begin
    int n;
    int dones;
    int hi;
    int bad;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'hF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  4'h3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,         32'h0,          4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678,  4'h8, 1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    boot_valid = 1'b0; boot_addr = '0; boot_data = '0;
    boot_busy = 1'b0; boot_error = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state and automatic release
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_load_error", 64'(load_error), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_boot_done", 64'(boot_done), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
    reset = 1'b0;
    hi = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (cpu_reset) hi++;
      if (boot_done) dones++;
      tick();
    end
    chk("t1_reset_cycles", 64'(hi), 64'd16);
    chk("t1_boot_done_count", 64'(dones), 64'd1);

    for (int i = 0; i < 4; i++) begin
      cpu_req   = vecs[i].cpu_req;
      cpu_we    = vecs[i].cpu_we;
      cpu_addr  = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      cpu_be    = vecs[i].be;
      mem_ready = vecs[i].mem_ready;
      tick();
      chk($sformatf("idle_req_we_rdy[%0d]", i), {61'd0, mem_req, mem_we, cpu_ready},
          {61'd0, vecs[i].exp_req, vecs[i].exp_we, vecs[i].exp_ready});
      chk($sformatf("idle_addr_data[%0d]", i), {mem_addr, mem_wdata}, {vecs[i].addr, vecs[i].wdata});
      chk($sformatf("idle_be[%0d]", i), 64'(mem_be), 64'(vecs[i].be));
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;

    // 2: four words streamed straight through
    start_load(1'b1);
    chk("t2_cpu_reset", 64'(cpu_reset), 64'd1);
    for (int i = 0; i < 4; i++) push_word(32'(i), 32'hA0 + 32'(i), 1'b1);
    boot_busy = 1'b0;
    wait_release(n, dones);
    // one pop, one empty DRAIN cycle, then 16 RELEASE cycles
    chk("t2_release_cycles", 64'(n), 64'd18);
    chk("t2_boot_done", 64'(dones), 64'd1);
    chk("t2_words", 64'(words_loaded), 64'd4);
    chk("t2_load_error", 64'(load_error), 64'd0);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3: overflow while memory stalls
    start_load(1'b0);
    for (int i = 0; i < 4; i++) push_word(32'h20 + 32'(i), 32'hB0 + 32'(i), 1'b1);
    chk("t3_full_no_error", 64'(load_error), 64'd0);
    push_word(32'h24, 32'hB4, 1'b0);
    chk("t3_overflow_error", 64'(load_error), 64'd1);
    chk("t3_stall_words", 64'(words_loaded), 64'd0);
    mem_ready = 1'b1;
    boot_busy = 1'b0;
    wait_release(n, dones);
    chk("t3_release_cycles", 64'(n), 64'd21);
    chk("t3_words", 64'(words_loaded), 64'd4);
    chk("t3_error_sticky", 64'(load_error), 64'd1);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: push and pop together while full
    start_load(1'b0);
    chk("t4_error_cleared", 64'(load_error), 64'd0);
    chk("t4_words_cleared", 64'(words_loaded), 64'd0);
    for (int i = 0; i < 4; i++) push_word(32'h40 + 32'(i), 32'hC0 + 32'(i), 1'b1);
    mem_ready = 1'b1;
    for (int i = 4; i < 7; i++) push_word(32'h40 + 32'(i), 32'hC0 + 32'(i), 1'b1);
    chk("t4_no_error", 64'(load_error), 64'd0);
    boot_busy = 1'b0;
    wait_release(n, dones);
    chk("t4_words", 64'(words_loaded), 64'd7);
    chk("t4_load_error", 64'(load_error), 64'd0);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: parser error mid-load stays set through release
    start_load(1'b1);
    push_word(32'h60, 32'hD0, 1'b1);
    push_word(32'h61, 32'hD1, 1'b1);
    boot_error = 1'b1;
    tick();
    boot_error = 1'b0;
    chk("t5_error_set", 64'(load_error), 64'd1);
    push_word(32'h62, 32'hD2, 1'b1);
    boot_busy = 1'b0;
    wait_release(n, dones);
    chk("t5_boot_done", 64'(dones), 64'd1);
    chk("t5_error_after_release", 64'(load_error), 64'd1);
    chk("t5_words", 64'(words_loaded), 64'd3);

    // 6: busy returns during RELEASE, same load continues
    start_load(1'b1);
    chk("t6_error_cleared", 64'(load_error), 64'd0);
    chk("t6_words_cleared", 64'(words_loaded), 64'd0);
    for (int i = 0; i < 3; i++) push_word(32'h80 + 32'(i), 32'hE0 + 32'(i), 1'b1);
    boot_busy = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (!cpu_reset || boot_done) bad++;
    end
    boot_busy = 1'b1;
    tick();
    if (!cpu_reset || boot_done) bad++;
    chk("t6_no_early_release", 64'(bad), 64'd0);
    chk("t6_words_mid", 64'(words_loaded), 64'd3);
    push_word(32'h83, 32'hE3, 1'b1);
    push_word(32'h84, 32'hE4, 1'b1);
    boot_busy = 1'b0;
    wait_release(n, dones);
    chk("t6_boot_done", 64'(dones), 64'd1);
    chk("t6_words", 64'(words_loaded), 64'd5);
    chk("t6_load_error", 64'(load_error), 64'd0);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
